servo_pwm_core: RTL and testbench

Servo pulse generator that sits directly downstream of the side-servo AXI4-Lite register slave. It consumes the slave's register outputs (control, target pulse width, sweep limits, step size) and drives the servo PWM pin with a frame-synchronous 50 Hz pulse. It supports manual positioning and an autonomous slew-limited sweep for the 2D ultrasonic radar. It reports the current position and a frame strobe back to the register file and the ranging logic.

---
 rtl/servo_pwm_core_if.sv | 27 ++
 rtl/servo_pwm_core.sv | 195 +++++++++++++++++++
 tb/tb_servo_pwm_core.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_core_if.sv
// Register-file side of the servo pulse generator: shadowed configuration in,
// pin state and position/status back out.
interface servo_pwm_core_if;
  logic        cfg_valid;
  logic        ctrl_enable;
  logic        ctrl_mode;
  logic [7:0]  step_us;
  logic [15:0] pw_target;
  logic [15:0] sweep_lo;
  logic [15:0] sweep_hi;

  logic        pwm_out;
  logic [15:0] pw_current;
  logic        frame_start;
  logic        sweep_dir;
  logic        at_target;

  modport master (
    output cfg_valid, ctrl_enable, ctrl_mode, step_us, pw_target, sweep_lo, sweep_hi,
    input  pwm_out, pw_current, frame_start, sweep_dir, at_target
  );

  modport slave (
    input  cfg_valid, ctrl_enable, ctrl_mode, step_us, pw_target, sweep_lo, sweep_hi,
    output pwm_out, pw_current, frame_start, sweep_dir, at_target
  );
endinterface

// File: rtl/servo_pwm_core.sv
// Frame-synchronous servo PWM generator with manual positioning and a
// slew-limited autonomous sweep; configuration is shadowed to frame boundaries.
module servo_pwm_core #(
  parameter int TICK_DIV     = 100,
  parameter int FRAME_US     = 20000,
  parameter int PW_MIN_US    = 500,
  parameter int PW_MAX_US    = 2500,
  parameter int PW_CENTER_US = 1500
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  servo_pwm_core_if.slave  regs
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [UW-1:0] US_LAST   = UW'(FRAME_US - 1);
  localparam logic [15:0]   PW_MIN_L  = 16'(PW_MIN_US);
  localparam logic [15:0]   PW_MAX_L  = 16'(PW_MAX_US);
  localparam logic [15:0]   PW_CTR_L  = 16'(PW_CENTER_US);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  function automatic logic [15:0] clamp_pw(input logic [15:0] v);
    if (v < PW_MIN_L)      return PW_MIN_L;
    else if (v > PW_MAX_L) return PW_MAX_L;
    else                   return v;
  endfunction

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [UW-1:0] us_cnt_reg, us_cnt_next;
  logic          pwm_reg;
  logic          frame_start_reg;
  logic [15:0]   pw_current_reg;
  logic          sweep_dir_reg;
  logic          at_target_reg;

  logic          mode_sh_reg;
  logic [7:0]    step_sh_reg;
  logic [15:0]   target_sh_reg;
  logic [15:0]   lo_sh_reg;
  logic [15:0]   hi_sh_reg;

  logic          tick_last;
  logic          frame_end;
  logic          pulse_end;
  logic          boundary;
  logic [15:0]   us_ext;

  // Clamp target, lo and hi in parallel as they are consumed.
  logic [15:0] raw_sh  [3];
  logic [15:0] clamped [3];

  assign raw_sh[0] = target_sh_reg;
  assign raw_sh[1] = lo_sh_reg;
  assign raw_sh[2] = hi_sh_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
      assign clamped[gi] = clamp_pw(raw_sh[gi]);
    end
  endgenerate

  logic [15:0]        target_c, lo_c, hi_c;
  logic               sweep_hold;
  logic [15:0]        eff_target;
  logic signed [16:0] diff;
  logic [15:0]        diff_mag;
  logic [15:0]        step_ext;
  logic [15:0]        pw_new;
  logic               reached;
  logic               dir_new;
  logic               at_new;

  assign target_c = clamped[0];
  assign lo_c     = clamped[1];
  assign hi_c     = clamped[2];
  assign us_ext   = 16'(us_cnt_reg);

  // Timebase and pulse FSM
  always_comb begin
    tick_last   = (tick_cnt_reg == TICK_LAST);
    frame_end   = tick_last && (us_cnt_reg == US_LAST);
    pulse_end   = tick_last && (us_ext == pw_current_reg - 16'd1);
    state_next  = state_reg;
    boundary    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (regs.ctrl_enable) begin
          state_next = ST_HIGH;
          boundary   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (pulse_end) state_next = ST_LOW;
      end
      ST_LOW: begin
        if (frame_end) begin
          if (regs.ctrl_enable) begin
            state_next = ST_HIGH;
            boundary   = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Counters wrap to zero exactly at the frame end, so a boundary from LOW
    // and a boundary from IDLE both start the new frame at (0,0).
    tick_cnt_next = '0;
    us_cnt_next   = '0;
    if (state_reg != ST_IDLE) begin
      if (tick_last) begin
        tick_cnt_next = '0;
        us_cnt_next   = (us_cnt_reg == US_LAST) ? '0 : us_cnt_reg + 1'b1;
      end else begin
        tick_cnt_next = tick_cnt_reg + 1'b1;
        us_cnt_next   = us_cnt_reg;
      end
    end
  end

  // Boundary update: slew pw_current toward the effective target.
  always_comb begin
    sweep_hold = (lo_c >= hi_c);
    if (!mode_sh_reg)    eff_target = target_c;
    else if (sweep_hold) eff_target = lo_c;
    else                 eff_target = sweep_dir_reg ? hi_c : lo_c;

    diff     = $signed({1'b0, eff_target}) - $signed({1'b0, pw_current_reg});
    diff_mag = diff[16] ? 16'(-diff) : diff[15:0];
    step_ext = {8'd0, step_sh_reg};

    if ((step_sh_reg == 8'd0) || (diff_mag <= step_ext)) pw_new = eff_target;
    else if (diff[16])                                   pw_new = pw_current_reg - step_ext;
    else                                                 pw_new = pw_current_reg + step_ext;

    reached = (pw_new == eff_target);
    dir_new = sweep_dir_reg;
    if (mode_sh_reg && !sweep_hold && reached) dir_new = ~sweep_dir_reg;
    at_new  = reached && !(mode_sh_reg && sweep_hold);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_reg       <= ST_IDLE;
      tick_cnt_reg    <= '0;
      us_cnt_reg      <= '0;
      pwm_reg         <= 1'b0;
      frame_start_reg <= 1'b0;
      pw_current_reg  <= PW_CTR_L;
      sweep_dir_reg   <= 1'b1;
      at_target_reg   <= 1'b0;
      mode_sh_reg     <= 1'b0;
      step_sh_reg     <= 8'd0;
      target_sh_reg   <= PW_CTR_L;
      lo_sh_reg       <= PW_MIN_L;
      hi_sh_reg       <= PW_MAX_L;
    end else begin
      state_reg       <= state_next;
      tick_cnt_reg    <= tick_cnt_next;
      us_cnt_reg      <= us_cnt_next;
      pwm_reg         <= (state_next == ST_HIGH);
      frame_start_reg <= boundary;
      if (boundary) begin
        pw_current_reg <= pw_new;
        sweep_dir_reg  <= dir_new;
        at_target_reg  <= at_new;
      end
      // A write landing on the boundary edge is seen only by the next boundary.
      if (regs.cfg_valid) begin
        mode_sh_reg   <= regs.ctrl_mode;
        step_sh_reg   <= regs.step_us;
        target_sh_reg <= regs.pw_target;
        lo_sh_reg     <= regs.sweep_lo;
        hi_sh_reg     <= regs.sweep_hi;
      end
    end
  end

  assign regs.pwm_out     = pwm_reg;
  assign regs.pw_current  = pw_current_reg;
  assign regs.frame_start = frame_start_reg;
  assign regs.sweep_dir   = sweep_dir_reg;
  assign regs.at_target   = at_target_reg;

endmodule

// File: tb/tb_servo_pwm_core.sv
// Directed plus randomized frame-level check of servo_pwm_core against an
// arithmetic model of the positioning rules.
module tb_servo_pwm_core;

  localparam int TD   = 10;
  localparam int FR   = 200;
  localparam int PMIN = 50;
  localparam int PMAX = 150;
  localparam int PCTR = 100;
  localparam int N    = TD * FR;

  logic clk;
  logic rst_n;

  servo_pwm_core_if bus ();

  servo_pwm_core #(
    .TICK_DIV(TD), .FRAME_US(FR), .PW_MIN_US(PMIN), .PW_MAX_US(PMAX), .PW_CENTER_US(PCTR)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .regs          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int frame_no    = 0;

  // Model state: shadows plus position, direction, at_target.
  int m_mode, m_step, m_tgt, m_lo, m_hi;
  int m_pw, m_dir, m_at;

  function automatic int clampv(input int v);
    return (v < PMIN) ? PMIN : ((v > PMAX) ? PMAX : v);
  endfunction

  function automatic bit model_hold();
    return (m_mode != 0) && (clampv(m_lo) >= clampv(m_hi));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_tgt = PCTR; m_lo = PMIN; m_hi = PMAX;
    m_pw = PCTR; m_dir = 1; m_at = 0;
  endtask

  task automatic model_load();
    m_mode = int'(bus.ctrl_mode);
    m_step = int'(bus.step_us);
    m_tgt  = int'(bus.pw_target);
    m_lo   = int'(bus.sweep_lo);
    m_hi   = int'(bus.sweep_hi);
  endtask

  task automatic model_boundary();
    int lo, hi, eff, d, mag;
    lo = clampv(m_lo);
    hi = clampv(m_hi);
    if (m_mode == 0)  eff = clampv(m_tgt);
    else if (lo >= hi) eff = lo;
    else               eff = (m_dir != 0) ? hi : lo;
    d   = eff - m_pw;
    mag = (d < 0) ? -d : d;
    if (m_step == 0 || mag <= m_step) m_pw = eff;
    else                              m_pw = m_pw + ((d > 0) ? m_step : -m_step);
    m_at = (m_pw == eff && !model_hold()) ? 1 : 0;
    if (m_mode != 0 && lo < hi && m_pw == eff) m_dir = 1 - m_dir;
  endtask

  task automatic set_cfg(input int mode, input int step, input int tgt, input int lo, input int hi);
    bus.ctrl_mode = mode[0];
    bus.step_us   = step[7:0];
    bus.pw_target = tgt[15:0];
    bus.sweep_lo  = lo[15:0];
    bus.sweep_hi  = hi[15:0];
  endtask

  task automatic start_from_idle();
    bus.ctrl_enable = 1'b1;
    tick();
    model_boundary();
  endtask

  // Entered on a frame_start sample; leaves on the next frame's first cycle.
  task automatic run_frame(input int cfg_at, input int dis_at);
    int high, extra, exp_high;
    bit hold;
    exp_high = m_pw * TD;
    hold     = model_hold();
    chk("frame_start", bus.frame_start, 1);
    chk("pw_current", bus.pw_current, m_pw);
    if (!hold) begin
      chk("at_target", bus.at_target, m_at);
      chk("sweep_dir", bus.sweep_dir, m_dir);
    end
    high  = 0;
    extra = 0;
    for (int c = 0; c < N; c++) begin
      if (c > 0 && bus.frame_start) extra++;
      if (bus.pwm_out) high++;
      if (c == dis_at) bus.ctrl_enable = 1'b0;
      bus.cfg_valid = (c == cfg_at);
      if (c == cfg_at && c != N - 1) model_load();
      tick();
    end
    bus.cfg_valid = 1'b0;
    chk("high_cycles", high, exp_high);
    chk("early_frame_start", extra, 0);
    if (bus.ctrl_enable) begin
      model_boundary();
    end else begin
      chk("idle_frame_start", bus.frame_start, 0);
      chk("idle_pwm", bus.pwm_out, 0);
    end
    if (cfg_at == N - 1) model_load();
    $display("frame %0d: width %0d us, high %0d cycles, cfg_at %0d, next pw %0d dir %0d",
             frame_no, exp_high / TD, high, cfg_at, m_pw, m_dir);
    frame_no++;
  endtask

  initial begin
    int fs_cnt, pw_cnt, rlo, rhi;
    rst_n = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.ctrl_enable = 1'b0;
    set_cfg(0, 0, PCTR, PMIN, PMAX);
    model_reset();
    repeat (3) tick();
    chk("rst_pwm", bus.pwm_out, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_at_target", bus.at_target, 0);
    chk("rst_sweep_dir", bus.sweep_dir, 1);
    chk("rst_pw_current", bus.pw_current, PCTR);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_pwm0", bus.pwm_out, 0);

    // Manual, no cfg write: centre pulse every frame.
    start_from_idle();
    run_frame(-1, -1);
    run_frame(-1, -1);

    // Mid-frame jump to 130.
    set_cfg(0, 0, 130, PMIN, PMAX);
    run_frame(500, -1);
    run_frame(-1, -1);

    // Slew 10 us/frame toward 145.
    set_cfg(0, 10, 145, PMIN, PMAX);
    run_frame(900, -1);
    repeat (5) run_frame(-1, -1);

    // Back to centre, then sweep 60..90 at 15 us/frame.
    set_cfg(0, 0, 100, 60, 90);
    run_frame(300, -1);
    set_cfg(1, 15, 100, 60, 90);
    run_frame(300, -1);
    repeat (5) run_frame(-1, -1);

    // Write coincident with the boundary, clamping target 300 -> 150.
    set_cfg(0, 0, 300, 60, 90);
    run_frame(N - 1, -1);
    run_frame(-1, -1);
    run_frame(-1, -1);

    // Inverted sweep bounds hold at clamped lo.
    set_cfg(1, 0, 100, 120, 80);
    run_frame(700, -1);
    run_frame(-1, -1);
    run_frame(-1, -1);

    // Randomized configurations and write positions.
    for (int r = 0; r < 8; r++) begin
      rlo = $urandom_range(30, 170);
      rhi = $urandom_range(30, 170);
      set_cfg($urandom_range(0, 1), $urandom_range(0, 40), $urandom_range(30, 170), rlo, rhi);
      run_frame((r % 3 == 2) ? N - 1 : $urandom_range(0, N - 1), -1);
    end

    // Disable 100 cycles into HIGH: frame completes, then IDLE.
    run_frame(-1, 100);
    fs_cnt = 0;
    pw_cnt = 0;
    for (int c = 0; c < 2500; c++) begin
      if (bus.frame_start) fs_cnt++;
      if (bus.pwm_out) pw_cnt++;
      tick();
    end
    chk("idle_no_frames", fs_cnt, 0);
    chk("idle_no_pulse", pw_cnt, 0);

    // Reset mid-pulse.
    start_from_idle();
    chk("restart_frame_start", bus.frame_start, 1);
    repeat (50) tick();
    chk("mid_high_pwm", bus.pwm_out, 1);
    rst_n = 1'b0;
    tick();
    bus.ctrl_enable = 1'b0;
    model_reset();
    chk("rst_mid_pwm", bus.pwm_out, 0);
    chk("rst_mid_pw_current", bus.pw_current, m_pw);
    chk("rst_mid_dir", bus.sweep_dir, m_dir);
    chk("rst_mid_at_target", bus.at_target, m_at);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
